// File: rtl/uart_mode_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_mode_cmd_tx
// Description : Host-side command issuer for the UART mode-control channel.
//               Single-cycle mode requests (green / red / normal) become the
//               command bytes 0x47, 0x72 and NORMAL_BYTE. The bytes are queued
//               in a small FIFO and sent 8N1, LSB first, on tx. mode_sent
//               reports the last command fully sent, using the interceptor's
//               2-bit state code (00 normal, 01 red, 10 green).
// Ports       : clk        - system clock
//               rst        - asynchronous reset, active low
//               req_green  - pulse: queue 8'h47
//               req_red    - pulse: queue 8'h72
//               req_normal - pulse: queue NORMAL_BYTE
//               tx         - serial output, idle high (registered)
//               busy       - frame in progress (registered)
//               fifo_full  - queue holds FIFO_DEPTH entries
//               drop_cnt   - requests lost to a full queue, saturates at 255
//               mode_sent  - last completed command code
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mode_cmd_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] NORMAL_BYTE  = 8'h4E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_green,
    input  logic       req_red,
    input  logic       req_normal,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_cnt,
    output logic [1:0] mode_sent
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]    c_PTR_ONE   = (c_PTR_W + 1)'(1);

    localparam logic [7:0] c_GREEN_BYTE = 8'h47;
    localparam logic [7:0] c_RED_BYTE   = 8'h72;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic [7:0]       r_drop_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_req_any;
    logic [7:0]       w_req_byte;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot but different lap: the writer is a full lap ahead.
    assign w_full  = (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]) &&
                     (r_wr_ptr[c_PTR_W]     != r_rd_ptr[c_PTR_W]);

    assign w_req_any  = req_green | req_red | req_normal;
    // Fixed priority; losers in the same cycle simply vanish.
    assign w_req_byte = req_green ? c_GREEN_BYTE :
                        req_red   ? c_RED_BYTE   : NORMAL_BYTE;
    // Fullness is judged on the registered pointers, so a pop in the same
    // cycle does not make room for a request.
    assign w_push     = w_req_any & ~w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_req_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_req_any && w_full && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // 8N1 serialiser
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [7:0]          r_byte;
    logic                r_tx;
    logic                r_busy;
    logic [1:0]          r_mode;

    logic [1:0]          w_state_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          w_byte_nxt;
    logic                w_tx_nxt;
    logic [1:0]          w_mode_nxt;
    logic                w_baud_last;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_nxt    = r_byte;
        w_mode_nxt    = r_mode;
        w_pop         = 1'b0;
        // tx follows the current state one clock later, so the line level is
        // always a flop output and the frame lags the FSM by one cycle.
        w_tx_nxt      = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr[c_PTR_W-1:0]];
                    w_byte_nxt  = r_mem[r_rd_ptr[c_PTR_W-1:0]];
                    w_baud_nxt  = '0;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_last) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = c_ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            c_ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin // c_ST_STOP
                w_tx_nxt = 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = c_ST_IDLE;
                    if (r_byte == c_GREEN_BYTE) begin
                        w_mode_nxt = 2'b10;
                    end else if (r_byte == c_RED_BYTE) begin
                        w_mode_nxt = 2'b01;
                    end else begin
                        w_mode_nxt = 2'b00;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_mode    <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_byte    <= w_byte_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            r_mode    <= w_mode_nxt;
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_full = w_full;
    assign drop_cnt  = r_drop_cnt;
    assign mode_sent = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_uart_mode_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mode_cmd_tx
// Description : Directed self-checking bench for uart_mode_cmd_tx with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4. A line monitor decodes every
//               frame on tx (byte, start cycle, stop bit, mode_sent at the
//               last stop cycle) into queues that the tests consume.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mode_cmd_tx;

    localparam int         c_CPB   = 4;
    localparam int         c_DEPTH = 4;
    localparam logic [7:0] c_NB    = 8'h4E;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_green;
    logic       req_red;
    logic       req_normal;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [7:0] drop_cnt;
    logic [1:0] mode_sent;

    uart_mode_cmd_tx #(
        .CLKS_PER_BIT (c_CPB),
        .FIFO_DEPTH   (c_DEPTH),
        .NORMAL_BYTE  (c_NB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_green  (req_green),
        .req_red    (req_red),
        .req_normal (req_normal),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt),
        .mode_sent  (mode_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    int         mon_off = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_stop_ok = 1'b0;
    logic [7:0] q_byte[$];
    int         q_start[$];
    logic [1:0] q_mode[$];
    logic       q_stop[$];

    // Offset 0 = first low sample; data bit k sampled at 6+4k, stop at 38,
    // last stop cycle at 39.
    always @(negedge clk) begin
        if (!rst) begin
            mon_off <= 0;
        end else if (mon_off == 0) begin
            if (tx === 1'b0) begin
                mon_off   <= 1;
                mon_start <= cyc;
            end
        end else begin
            mon_off <= mon_off + 1;
            if (mon_off >= 6 && mon_off <= 34 && ((mon_off - 6) % 4) == 0)
                mon_byte <= {tx, mon_byte[7:1]};
            if (mon_off == 38)
                mon_stop_ok <= (tx === 1'b1);
            if (mon_off == 39) begin
                q_byte.push_back(mon_byte);
                q_start.push_back(mon_start);
                q_mode.push_back(mode_sent);
                q_stop.push_back(mon_stop_ok);
                mon_off <= 0;
            end
        end
    end

    task automatic flush_frames();
        q_byte.delete();
        q_start.delete();
        q_mode.delete();
        q_stop.delete();
    endtask

    task automatic get_frame(input string tag, input logic [7:0] exp_b,
                             input logic [1:0] exp_m, output int start);
        int waited = 0;
        while (q_byte.size() == 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (q_byte.size() == 0) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            start = 0;
        end else begin
            check({tag, " byte"}, q_byte.pop_front(), exp_b);
            check({tag, " mode"}, q_mode.pop_front(), exp_m);
            check({tag, " stop"}, q_stop.pop_front(), 1);
            start = q_start.pop_front();
        end
    endtask

    task automatic pulse(input logic g, input logic r, input logic n);
        @(negedge clk);
        req_green = g; req_red = r; req_normal = n;
        @(negedge clk);
        req_green = 0; req_red = 0; req_normal = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int         mark, s1, s2, busy_cnt;
        logic [9:0] t1_line;
        logic [7:0] t4_b [5];
        logic [1:0] t4_m [5];
        int         t4_s [5];

        rst = 1'b0; req_green = 0; req_red = 0; req_normal = 0;
        repeat (3) @(negedge clk);
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst full", fifo_full, 0);
        check("rst drop", drop_cnt, 0);
        check("rst mode", mode_sent, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- 1: single green, cycle-exact line ----
        t1_line = 10'b1_01000111_0;
        pulse(1, 0, 0);
        mark = cyc;
        check("t1 tx@N", tx, 1);
        check("t1 busy@N", busy, 0);
        @(negedge clk);
        check("t1 tx@N+1", tx, 1);
        check("t1 busy@N+1", busy, 1);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("t1 line c%0d", i), tx, t1_line[i/4]);
            if (busy) busy_cnt++;
            if (i == 35) check("t1 mode before", mode_sent, 2'b00);
            if (i == 39) check("t1 mode last stop", mode_sent, 2'b10);
        end
        check("t1 busy cycles", busy_cnt, 40);
        check("t1 busy end", busy, 0);
        get_frame("t1", 8'h47, 2'b10, s1);
        check("t1 latency", s1 - mark, 2);

        // ---- 2: red then normal, back to back ----
        @(negedge clk); req_red = 1;
        @(negedge clk); req_red = 0; req_normal = 1;
        @(negedge clk); req_normal = 0;
        get_frame("t2a", 8'h72, 2'b01, s1);
        get_frame("t2b", c_NB, 2'b00, s2);
        check("t2 spacing", s2 - s1, 41);

        // ---- 3: green and red together ----
        pulse(1, 1, 0);
        get_frame("t3", 8'h47, 2'b10, s1);
        repeat (60) @(negedge clk);
        check("t3 extra frames", q_byte.size(), 0);
        check("t3 busy", busy, 0);
        check("t3 drop", drop_cnt, 0);

        // ---- 4: six pulses, depth 4 ----
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_green = (i % 3 == 0); req_red = (i % 3 == 1); req_normal = (i % 3 == 2);
        end
        @(negedge clk);
        req_green = 0; req_red = 0; req_normal = 0;
        check("t4 full", fifo_full, 1);
        check("t4 drop", drop_cnt, 1);
        t4_b = '{8'h47, 8'h72, 8'h4E, 8'h47, 8'h72};
        t4_m = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 5; i++) begin
            get_frame($sformatf("t4 f%0d", i), t4_b[i], t4_m[i], t4_s[i]);
            if (i > 0) check($sformatf("t4 spacing%0d", i), t4_s[i] - t4_s[i-1], 41);
        end
        repeat (100) @(negedge clk);
        check("t4 extra frames", q_byte.size(), 0);
        check("t4 drop after", drop_cnt, 1);

        // ---- 5: drop counter saturation ----
        @(negedge clk); req_green = 1;
        repeat (305) @(negedge clk);
        req_green = 0;
        check("t5 drop sat", drop_cnt, 8'd255);
        repeat (300) @(negedge clk);
        check("t5 drop hold", drop_cnt, 8'd255);
        check("t5 drained", busy, 0);
        check("t5 mode", mode_sent, 2'b10);
        flush_frames();

        // ---- 6: asynchronous reset during data bit 3 ----
        @(negedge clk); req_green = 1;
        @(negedge clk); req_green = 0; req_red = 1;
        @(negedge clk); req_red = 0; req_normal = 1;
        @(negedge clk); req_normal = 0;
        repeat (17) @(negedge clk);
        check("t6 bit3 level", tx, 0);
        check("t6 busy pre", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t6 rst tx", tx, 1);
        check("t6 rst busy", busy, 0);
        check("t6 rst full", fifo_full, 0);
        check("t6 rst drop", drop_cnt, 0);
        check("t6 rst mode", mode_sent, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("t6 fifo emptied", q_byte.size(), 0);
        check("t6 idle busy", busy, 0);
        check("t6 idle tx", tx, 1);
        pulse(0, 0, 1);
        mark = cyc;
        get_frame("t6", c_NB, 2'b00, s1);
        check("t6 latency", s1 - mark, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
